// File: rtl/ctrl_pkg.sv
// Shared decode constants, E-stage control bundle and divide-sequencer state
// for the pipelined RV32 control unit.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SR  = 4'b0111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] branch;
    logic       jump;
    logic [2:0] r_size;
    logic [2:0] dmem_size;
    logic [3:0] alu;
    logic       illegal;
  } ctrl_bundle_t;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_t;

  // The 3-bit datapath code space folds SLTU into SLT and SRA into SR.
  function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    code = ALU_ADD;
    unique case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLT;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SR;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/div_sequencer.sv
// Multi-cycle divide sequencer: holds E busy for DIV_CYCLES-1 cycles after a
// divide is loaded; flush or reset abort back to idle.
module div_sequencer
  import ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_flush,
  output logic o_busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (DIV_CYCLES < 2) begin : g_bad_cycles
      $error("div_sequencer: DIV_CYCLES must be at least 2");
    end
  endgenerate

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        SEQ_IDLE: begin
          if (i_start) begin
            r_state <= SEQ_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        SEQ_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= SEQ_IDLE;
        end
        default: begin
          r_state <= SEQ_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy = (r_state == SEQ_BUSY);

endmodule

// File: rtl/control_unit_pipe.sv
// RV32 decode-to-execute control unit with registered D/E control bundle.
// Define RV32M_EN to decode the M extension and enable the divide sequencer.
module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrD,
  input  logic                  FlushE,
  output logic [2:0]            ImmSrcD,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  ALUsrcE,
  output logic [2:0]            BranchE,
  output logic                  JumpE,
  output logic [2:0]            R_sizeE,
  output logic [2:0]            DMem_sizeE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  IllegalE,
  output logic                  DivStall
);

  localparam int ALU_KEEP = (ALU_CTRL_W < 4) ? ALU_CTRL_W : 4;

  generate
    if (ALU_CTRL_W < 3) begin : g_bad_alu_w
      $error("control_unit_pipe: ALU_CTRL_W must be at least 3");
    end
`ifdef RV32M_EN
    if (ALU_CTRL_W < 4) begin : g_bad_alu_w_m
      $error("control_unit_pipe: ALU_CTRL_W must be at least 4 with RV32M");
    end
`endif
  endgenerate

  logic [6:0]   w_opcode;
  logic [2:0]   w_f3;
  logic [6:0]   w_f7;
  logic         w_unused_bits;
  ctrl_bundle_t w_dec;
  logic [2:0]   w_imm_src;
  logic         w_is_div;
  logic         w_busy;
  ctrl_bundle_t r_e;

  assign w_opcode      = InstrD[6:0];
  assign w_f3          = InstrD[14:12];
  assign w_f7          = InstrD[31:25];
  assign w_unused_bits = ^{InstrD[24:15], InstrD[11:7]};

  always_comb begin
    w_dec     = '0;
    w_imm_src = IMM_I;
    w_is_div  = 1'b0;
    unique case (w_opcode)
      OP_R: begin
        w_dec.reg_write = 1'b1;
        if (w_f7 == F7_BASE) begin
          w_dec.alu = alu_base(w_f3, 1'b0);
        end else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_dec.alu = alu_base(w_f3, 1'b1);
`ifdef RV32M_EN
        end else if (w_f7 == F7_MUL) begin
          w_dec.alu = {1'b1, w_f3};
          w_is_div  = w_f3[2];
`endif
        end else begin
          w_dec         = '0;
          w_dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        // Only the shift-right immediate carries an alternate-op bit in funct7.
        w_dec.alu       = alu_base(w_f3, (w_f3 == 3'b101) && w_f7[5]);
      end
      OP_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b01;
        w_dec.alu_src    = 1'b1;
        w_dec.r_size     = w_f3;
        w_dec.dmem_size  = w_f3;
        w_dec.alu        = ALU_ADD;
      end
      OP_STORE: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.dmem_size = w_f3;
        w_dec.alu       = ALU_ADD;
        w_imm_src       = IMM_S;
      end
      OP_BRANCH: begin
        w_dec.alu = ALU_SUB;
        w_imm_src = IMM_B;
        unique case (w_f3)
          3'b000:  w_dec.branch = 3'b001;
          3'b001:  w_dec.branch = 3'b010;
          3'b100:  w_dec.branch = 3'b011;
          3'b101:  w_dec.branch = 3'b100;
          3'b110:  w_dec.branch = 3'b101;
          3'b111:  w_dec.branch = 3'b110;
          default: w_dec.branch = 3'b000;
        endcase
      end
      OP_JAL: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.jump       = 1'b1;
        w_imm_src        = IMM_J;
      end
      OP_JALR: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.jump       = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.alu        = ALU_ADD;
      end
      OP_LUI: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b11;
        w_imm_src        = IMM_U;
      end
      OP_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu       = ALU_ADD;
        w_imm_src       = IMM_U;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  assign ImmSrcD = w_dec.illegal ? IMM_I : w_imm_src;

`ifdef RV32M_EN
  div_sequencer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_is_div),
    .i_flush (FlushE),
    .o_busy  (w_busy)
  );
`else
  assign w_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e <= '0;
    end else if (FlushE) begin
      r_e <= '0;
    end else if (!w_busy) begin
      r_e <= w_dec;
    end
  end

  // Write enables stay masked until the divide's final cycle in E.
  assign RegWriteE   = r_e.reg_write & ~w_busy;
  assign MemWriteE   = r_e.mem_write & ~w_busy;
  assign ResultSrcE  = r_e.result_src;
  assign ALUsrcE     = r_e.alu_src;
  assign BranchE     = r_e.branch;
  assign JumpE       = r_e.jump;
  assign R_sizeE     = r_e.r_size;
  assign DMem_sizeE  = r_e.dmem_size;
  assign ALUControlE = ALU_CTRL_W'(r_e.alu[ALU_KEEP-1:0]);
  assign IllegalE    = r_e.illegal;
  assign DivStall    = w_busy;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed self-checking bench for control_unit_pipe; the divide scenarios
// run only when RV32M_EN is defined, otherwise the M opcodes must trap.
module tb_control_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic        FlushE;
  logic [2:0]  ImmSrcD;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        ALUsrcE;
  logic [2:0]  BranchE;
  logic        JumpE;
  logic [2:0]  R_sizeE;
  logic [2:0]  DMem_sizeE;
  logic [3:0]  ALUControlE;
  logic        IllegalE;
  logic        DivStall;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ADD  = 32'h00208033;
  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3;
  localparam logic [31:0] I_REM  = 32'h0220E1B3;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  // {RegWrite, ResultSrc, MemWrite, ALUsrc, Branch, Jump, R_size, DMem_size, ALUControl, Illegal, DivStall}
  logic [20:0] obs;
  assign obs = {RegWriteE, ResultSrcE, MemWriteE, ALUsrcE, BranchE, JumpE,
                R_sizeE, DMem_sizeE, ALUControlE, IllegalE, DivStall};

  localparam logic [20:0] E_ZERO = '0;
  localparam logic [20:0] E_LW   = {1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 1'b0, 3'b010, 3'b010, 4'b0000, 1'b0, 1'b0};
  localparam logic [20:0] E_SW   = {1'b0, 2'b00, 1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 3'b010, 4'b0000, 1'b0, 1'b0};
  localparam logic [20:0] E_BEQ  = {1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000, 4'b0001, 1'b0, 1'b0};
  localparam logic [20:0] E_JAL  = {1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0};
  localparam logic [20:0] E_ADD  = {1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 4'b0000, 1'b0, 1'b0};
  localparam logic [20:0] E_SUB  = {1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 4'b0001, 1'b0, 1'b0};
  localparam logic [20:0] E_ILL  = {1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 4'b0000, 1'b1, 1'b0};
  localparam logic [20:0] E_MUL  = {1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 4'b1000, 1'b0, 1'b0};
  localparam logic [20:0] E_DIVB = {1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 4'b1100, 1'b0, 1'b1};
  localparam logic [20:0] E_DIVF = {1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 4'b1100, 1'b0, 1'b0};
  localparam logic [20:0] E_REMB = {1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 4'b1110, 1'b0, 1'b1};
  localparam logic [20:0] E_REMF = {1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 4'b1110, 1'b0, 1'b0};

  control_unit_pipe #(
    .ALU_CTRL_W(4),
    .DIV_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (InstrD),
    .FlushE      (FlushE),
    .ImmSrcD     (ImmSrcD),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .ALUsrcE     (ALUsrcE),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .R_sizeE     (R_sizeE),
    .DMem_sizeE  (DMem_sizeE),
    .ALUControlE (ALUControlE),
    .IllegalE    (IllegalE),
    .DivStall    (DivStall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; FlushE = 1'b0; InstrD = I_LW;
    tick(); tick();
    vectors++;
    if (obs !== E_ZERO) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", obs, E_ZERO);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (obs !== E_LW) begin
      miscompares++;
      $display("FAIL load_after_reset: got %h want %h", obs, E_LW);
    end
  endtask

  task automatic test_decode();
    logic [31:0] instrs [6];
    logic [20:0] exps   [6];
    logic [2:0]  imms   [6];
    instrs = '{I_ADD, I_SUB, I_SW, I_BEQ, I_JAL, I_BAD};
    exps   = '{E_ADD, E_SUB, E_SW, E_BEQ, E_JAL, E_ILL};
    imms   = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b000};
    for (int i = 0; i < 6; i++) begin
      InstrD = instrs[i];
      #1;
      vectors++;
      if (ImmSrcD !== imms[i]) begin
        miscompares++;
        $display("FAIL immsrc[%0d]: got %b want %b", i, ImmSrcD, imms[i]);
      end
      tick();
      vectors++;
      if (obs !== exps[i]) begin
        miscompares++;
        $display("FAIL decode[%0d] instr %h: got %h want %h", i, instrs[i], obs, exps[i]);
      end
    end
  endtask

`ifdef RV32M_EN
  task automatic test_mul();
    InstrD = I_MUL;
    tick();
    vectors++;
    if (obs !== E_MUL) begin
      miscompares++;
      $display("FAIL mul: got %h want %h", obs, E_MUL);
    end
    InstrD = I_ADD;
    tick();
    vectors++;
    if (obs !== E_ADD) begin
      miscompares++;
      $display("FAIL after_mul: got %h want %h", obs, E_ADD);
    end
  endtask

  task automatic test_divide();
    InstrD = I_DIV;
    #1;
    vectors++;
    if (DivStall !== 1'b0) begin
      miscompares++;
      $display("FAIL div_in_d_stall: got %b want 0", DivStall);
    end
    tick();
    InstrD = I_ADD;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs !== E_DIVB) begin
        miscompares++;
        $display("FAIL div_busy[%0d]: got %h want %h", k, obs, E_DIVB);
      end
      tick();
    end
    vectors++;
    if (obs !== E_DIVF) begin
      miscompares++;
      $display("FAIL div_final: got %h want %h", obs, E_DIVF);
    end
    tick();
    vectors++;
    if (obs !== E_ADD) begin
      miscompares++;
      $display("FAIL after_div: got %h want %h", obs, E_ADD);
    end
  endtask

  task automatic test_back_to_back();
    InstrD = I_DIV;
    tick();
    InstrD = I_REM;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs !== E_DIVB) begin
        miscompares++;
        $display("FAIL b2b_div_busy[%0d]: got %h want %h", k, obs, E_DIVB);
      end
      tick();
    end
    vectors++;
    if (obs !== E_DIVF) begin
      miscompares++;
      $display("FAIL b2b_div_final: got %h want %h", obs, E_DIVF);
    end
    tick();
    InstrD = I_ADD;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs !== E_REMB) begin
        miscompares++;
        $display("FAIL b2b_rem_busy[%0d]: got %h want %h", k, obs, E_REMB);
      end
      tick();
    end
    vectors++;
    if (obs !== E_REMF) begin
      miscompares++;
      $display("FAIL b2b_rem_final: got %h want %h", obs, E_REMF);
    end
    tick();
  endtask

  task automatic test_abort(input bit use_rst);
    InstrD = I_DIV;
    tick();
    InstrD = I_ADD;
    tick();
    vectors++;
    if (obs !== E_DIVB) begin
      miscompares++;
      $display("FAIL abort_pre[%0d]: got %h want %h", use_rst, obs, E_DIVB);
    end
    if (use_rst) rst = 1'b1;
    else FlushE = 1'b1;
    tick();
    rst = 1'b0; FlushE = 1'b0;
    vectors++;
    if (obs !== E_ZERO) begin
      miscompares++;
      $display("FAIL abort[%0d]: got %h want %h", use_rst, obs, E_ZERO);
    end
    tick();
    vectors++;
    if (obs !== E_ADD) begin
      miscompares++;
      $display("FAIL after_abort[%0d]: got %h want %h", use_rst, obs, E_ADD);
    end
  endtask
`else
  task automatic test_no_m();
    InstrD = I_DIV;
    tick();
    InstrD = I_ADD;
    vectors++;
    if (obs !== E_ILL) begin
      miscompares++;
      $display("FAIL no_m_div: got %h want %h", obs, E_ILL);
    end
    tick();
    vectors++;
    if (obs !== E_ADD) begin
      miscompares++;
      $display("FAIL no_m_after: got %h want %h", obs, E_ADD);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
`ifdef RV32M_EN
    test_mul();
    test_divide();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
`else
    test_no_m();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit_pipe.md
# control_unit_pipe

Registered, parametrised decode-to-execute control unit for the pipelined RV32 core. Decodes the instruction in D, drives the D-stage immediate select, and captures the full control bundle into the D/E boundary register with flush support. Optionally decodes RV32M. A built-in divide sequencer holds E and stalls the front end for multi-cycle DIV/REM.

## Interface
Parameters:
- `ALU_CTRL_W`, default 4: ALUControl width. Minimum 3; minimum 4 when RV32M is compiled in.
- `DIV_CYCLES`, default 33: total cycles a DIV/DIVU/REM/REMU occupies E. Minimum 2.

Ports:
- `clk` in 1: clock, one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `InstrD` in 32: D-stage instruction.
- `FlushE` in 1: hazard-unit bubble request for E.
- `ImmSrcD` out 3: combinational immediate select for the D-stage extender.
- `RegWriteE` out 1, `ResultSrcE` out 2, `MemWriteE` out 1, `ALUsrcE` out 1: registered E controls.
- `BranchE` out 3, `JumpE` out 1: registered branch/jump controls.
- `R_sizeE` out 3, `DMem_sizeE` out 3: load/store size and sign controls.
- `ALUControlE` out ALU_CTRL_W: registered ALU operation.
- `IllegalE` out 1: E holds an undecodable instruction.
- `DivStall` out 1: to the hazard unit; stall F and D while high.

## Operation
- Decoding:
  - Opcode drives RegWrite, ResultSrc, MemWrite, ALUsrc, ImmSrc, Branch, Jump, R_size and DMem_size, using the encodings the existing datapath consumes.
  - funct3 plus funct7[5] select the base ALU code. Base codes are the 3-bit datapath encodings, zero-extended to ALU_CTRL_W.
  - With RV32M, opcode 0110011 and funct7=0000001 encode as {1, funct3} in the low 4 bits.
- Unknown opcode: IllegalE=1 and all write enables forced 0. The other fields are don't-care but must be deterministic: all 0.
- E-register priority per edge:
  1. rst: all E outputs 0.
  2. FlushE: all E outputs 0, sequencer to IDLE.
  3. Sequencer BUSY: hold.
  4. Otherwise load the decoded bundle.
- Sequencer states:
  - IDLE: a div-class op (M, funct3[2]=1) being loaded into E moves to BUSY and sets cnt=DIV_CYCLES-1.
  - BUSY: cnt decrements each cycle. When cnt==1, the next state is IDLE.
- While BUSY:
  - DivStall=1.
  - RegWriteE and MemWriteE are presented as 0, while the held register keeps the real values.
  - The real values appear in the final cycle, when the state is IDLE and E still holds the op.
- MUL/MULH* are single-cycle and never enter BUSY.
- rst or FlushE mid-BUSY aborts: IDLE, cnt=0, DivStall=0 from the next cycle.

## Timing
- ImmSrcD: combinational from InstrD, zero latency.
- E outputs: one cycle after InstrD is presented.
- DivStall:
  - Combinational from state. Low in the cycle the div is first presented in D.
  - High for DIV_CYCLES-1 cycles starting the cycle after the edge that loads the div into E.
  - The div occupies E for DIV_CYCLES cycles total.
- Back-to-back divs: the second stays in D under DivStall. It loads at the edge ending the first div's final cycle, then starts a fresh count.
- Reset values: every output 0, state IDLE, cnt 0.

## Configuration
- `RV32M_EN` defined:
  - M-extension decoded.
  - Divide sequencer instantiated.
  - ALU_CTRL_W below 4 is an elaboration error.
- Undefined:
  - funct7=0000001 on opcode 0110011 sets IllegalE=1.
  - DivStall tied 0.
  - No sequencer logic.

## Structure
- Package `ctrl_pkg` holds:
  - Opcode localparams.
  - ALU code localparams.
  - The packed struct `ctrl_bundle_t` for the E-register fields.
  - The sequencer state enum.
- One sub-module: `div_sequencer` (FSM plus counter; inputs start, flush; output busy).
- Decode logic stays in this module.

## Test plan
- Reset: with rst=1 for 2 cycles and InstrD=0x0080A283 → all outputs 0. The cycle after release: RegWriteE=1, ResultSrcE=01, ALUsrcE=1, DMem_sizeE=010.
- ADD: InstrD=0x00208033 → next cycle RegWriteE=1, ALUsrcE=0, ALUControlE=0000, IllegalE=0, DivStall=0.
- Divide, with RV32M_EN and DIV_CYCLES=4: InstrD=0x0220C1B3 → DivStall high exactly 3 cycles. RegWriteE=0 during those cycles and 1 in the 4th. ALUControlE=1100 throughout.
- Single-cycle MUL: InstrD=0x022081B3 → ALUControlE=1000 next cycle, DivStall never asserted.
- Flush and abort: FlushE=1 in the 2nd BUSY cycle → next cycle all E outputs 0, DivStall=0. Same with rst=1 instead of FlushE.
- Illegal: InstrD=0xFFFFFFFF → IllegalE=1, RegWriteE=0, MemWriteE=0. Without RV32M_EN, InstrD=0x0220C1B3 → IllegalE=1, DivStall stays 0.
